// File: rtl/stage_sequencer.sv
// Top-level pipeline sequencer: walks the state register through the eight stages,
// launching each stage unit, waiting for its done, and guarding each stage with a watchdog.
`timescale 1ns/1ps
`ifndef STATE_LEN
`define STATE_LEN 4
`define IDLE 4'd0
`define RECV 4'd1
`define EMB  4'd2
`define MIX1 4'd3
`define MIX2 4'd4
`define MIX3 4'd5
`define DENS 4'd6
`define COMP 4'd7
`define SEND 4'd8
`endif

module stage_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 65536,
   parameter int unsigned CNT_W       = 17
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [`STATE_LEN-1:0] state,
   input  logic [7:0]            stage_done,
   output logic                  run,
   output logic                  set,
   output logic [`STATE_LEN-1:0] d,
   output logic [7:0]            stage_start,
   output logic                  busy,
   output logic                  pass_done,
   output logic                  timeout_err,
   output logic [1:0]            phase_dbg
);

   // Handshake: stage_start is a one-cycle launch; the unit answers with a one-cycle
   // stage_done on its own bit, accepted only while the sequencer waits in P_BUSY.
   typedef enum logic [1:0] {P_IDLE, P_SETTLE, P_LAUNCH, P_BUSY} phase_t;

   phase_t                  phase_q, phase_d;
   logic                    run_q, run_d;
   logic                    set_q, set_d;
   logic [`STATE_LEN-1:0]   d_q, d_d;
   logic [7:0]              ss_q, ss_d;
   logic                    busy_q, busy_d;
   logic                    pd_q, pd_d;
   logic                    te_q, te_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [7:0]              cur_q, cur_d;
   logic [7:0]              stage_oh;
   logic                    done_hit;
   logic                    wd_hit;

   always_comb begin
      stage_oh = '0;
      case (state)
         `RECV:   stage_oh = 8'h01;
         `EMB:    stage_oh = 8'h02;
         `MIX1:   stage_oh = 8'h04;
         `MIX2:   stage_oh = 8'h08;
         `MIX3:   stage_oh = 8'h10;
         `DENS:   stage_oh = 8'h20;
         `COMP:   stage_oh = 8'h40;
         `SEND:   stage_oh = 8'h80;
         default: stage_oh = '0;
      endcase
   end

   assign done_hit = |(stage_done & cur_q);
   assign wd_hit   = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      phase_d = phase_q;
      run_d   = 1'b0;
      set_d   = 1'b0;
      d_d     = `IDLE;
      ss_d    = '0;
      busy_d  = busy_q;
      pd_d    = 1'b0;
      te_d    = te_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      if (phase_q != P_IDLE && abort) begin
         set_d   = 1'b1;
         busy_d  = 1'b0;
         phase_d = P_IDLE;
      end else begin
         case (phase_q)
            P_IDLE: begin
               if (start && state == `IDLE) begin
                  run_d   = 1'b1;
                  busy_d  = 1'b1;
                  te_d    = 1'b0;
                  phase_d = P_SETTLE;
               end
            end
            // run is visible this cycle; the state register takes the new value at its end
            P_SETTLE: phase_d = P_LAUNCH;
            P_LAUNCH: begin
               if (state == `IDLE) begin
                  pd_d    = 1'b1;
                  busy_d  = 1'b0;
                  phase_d = P_IDLE;
               end else if (stage_oh == '0) begin
                  set_d   = 1'b1;
                  te_d    = 1'b1;
                  busy_d  = 1'b0;
                  phase_d = P_IDLE;
               end else begin
                  ss_d    = stage_oh;
                  cur_d   = stage_oh;
                  cnt_d   = '0;
                  phase_d = P_BUSY;
               end
            end
            P_BUSY: begin
               if (wd_hit) begin
                  set_d   = 1'b1;
                  te_d    = 1'b1;
                  busy_d  = 1'b0;
                  phase_d = P_IDLE;
               end else if (done_hit) begin
                  run_d   = 1'b1;
                  phase_d = P_SETTLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: phase_d = P_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= P_IDLE;
         run_q   <= 1'b0;
         set_q   <= 1'b0;
         d_q     <= `IDLE;
         ss_q    <= '0;
         busy_q  <= 1'b0;
         pd_q    <= 1'b0;
         te_q    <= 1'b0;
         cnt_q   <= '0;
         cur_q   <= '0;
      end else begin
         phase_q <= phase_d;
         run_q   <= run_d;
         set_q   <= set_d;
         d_q     <= d_d;
         ss_q    <= ss_d;
         busy_q  <= busy_d;
         pd_q    <= pd_d;
         te_q    <= te_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
      end
   end

   assign run         = run_q;
   assign set         = set_q;
   assign d           = d_q;
   assign stage_start = ss_q;
   assign busy        = busy_q;
   assign pass_done   = pd_q;
   assign timeout_err = te_q;
   assign phase_dbg   = phase_q;

endmodule
